// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state encoding, slot owner codes and slot timing for the DRAM arbiter
package ram_arb_pkg;
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ROW     = 3'd1;
    localparam logic [2:0] COL     = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] PRE     = 3'd4;
    localparam logic [2:0] RF_CAS  = 3'd5;
    localparam logic [2:0] RF_RAS  = 3'd6;
    localparam logic [2:0] RF_HOLD = 3'd7;
    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_VID = 2'd1;
    localparam logic [1:0] OWN_SND = 2'd2;
    localparam logic [1:0] OWN_REF = 2'd3;
    localparam int SLOT_LEN = 5;
    localparam int ACK_LAT  = 3;
endpackage

// File: rtl/ram_refresh_timer.sv
// ram_refresh_timer: free-running refresh countdown raising a sticky refresh-pending flag
module ram_refresh_timer #(
    parameter int PERIOD = 250,
    parameter int W = 8
) (
    input  logic CLK,
    input  logic RES,
    input  logic clr,
    output logic ref_pend
);
    logic [W-1:0] cnt;
    // count down, reload at zero and flag a refresh; a new expiry wins over a same-cycle clear
    always_ff @(posedge CLK) begin
        if (RES) begin
            cnt      <= W'(PERIOD - 1);
            ref_pend <= 1'b0;
        end else begin
            cnt      <= (cnt == '0) ? W'(PERIOD - 1) : cnt - 1'b1;
            ref_pend <= (cnt == '0) | (ref_pend & ~clr);
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: slot arbiter sharing DRAM between CPU, video, sound and refresh (refresh built with RAM_REFRESH_EN)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int REFRESH_PERIOD = 250,
    parameter int REFRESH_W = 8
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       RAMCS,
    input  logic       CACT,
    input  logic       nWE,
    input  logic       VidReq,
    input  logic       SndReq,
    output logic       nRAS,
    output logic       nCAS,
    output logic       nRAMWE,
    output logic       RowSel,
    output logic [1:0] Owner,
    output logic       RAMRDY,
    output logic       VidAck,
    output logic       SndAck
);
    logic [2:0] state, nxt;
    logic [1:0] nxt_own;
    logic cpu_served, cpu_pri, we_l, ref_pend, cpu_req, idle, go, grant_cpu;
    assign cpu_req = RAMCS & CACT & ~cpu_served;
    assign idle    = state == IDLE;
    assign go      = ref_pend | cpu_req | VidReq | SndReq;
`ifdef RAM_REFRESH_EN
    ram_refresh_timer #(.PERIOD(REFRESH_PERIOD), .W(REFRESH_W)) u_timer (
        .CLK(CLK),
        .RES(RES),
        .clr(idle & ref_pend),
        .ref_pend(ref_pend)
    );
`else
    assign ref_pend = 1'b0;
`endif
    // grant decision and fixed slot sequencing
    always_comb begin
        grant_cpu = cpu_req & (cpu_pri | ~(VidReq | SndReq));
        nxt_own   = ref_pend ? OWN_REF : grant_cpu ? OWN_CPU : VidReq ? OWN_VID : OWN_SND;
        nxt       = idle ? (ref_pend ? RF_CAS : go ? ROW : IDLE) :
                    state == ROW     ? COL :
                    state == COL     ? DATA :
                    state == DATA    ? PRE :
                    state == RF_CAS  ? RF_RAS :
                    state == RF_RAS  ? RF_HOLD :
                    state == RF_HOLD ? PRE : IDLE;
    end
    // slot state, latched owner/write strobe and CPU fairness bookkeeping
    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= IDLE;
            Owner      <= OWN_CPU;
            we_l       <= 1'b1;
            cpu_served <= 1'b0;
            cpu_pri    <= 1'b0;
        end else begin
            state <= nxt;
            if (idle & go) begin
                Owner <= nxt_own;
                we_l  <= (nxt_own == OWN_CPU) ? nWE : 1'b1;
            end
            cpu_served <= CACT & (cpu_served | (state == DATA & Owner == OWN_CPU));
            cpu_pri    <= ~CACT ? 1'b0 :
                          (idle & ~ref_pend & grant_cpu) ? 1'b0 :
                          (idle & ~ref_pend & (VidReq | SndReq) & cpu_req) ? 1'b1 : cpu_pri;
        end
    end
    assign nRAS   = ~(state inside {ROW, COL, DATA, RF_RAS, RF_HOLD});
    assign nCAS   = ~(state inside {COL, DATA, RF_CAS, RF_RAS, RF_HOLD});
    assign RowSel = ~(state inside {COL, DATA});
    assign nRAMWE = (state inside {ROW, COL, DATA}) ? we_l : 1'b1;
    assign RAMRDY = (state == DATA) & (Owner == OWN_CPU);
    assign VidAck = (state == DATA) & (Owner == OWN_VID);
    assign SndAck = (state == DATA) & (Owner == OWN_SND);
endmodule
